// File: rtl/pulse_stretcher_if.sv
// Event-request / stretched-pulse bundle between the control logic and the output pins.
interface pulse_stretcher_if;
    logic       in;
    logic       out;
    logic       busy;
    logic [7:0] dropped;

    modport master (output in, input out, input busy, input dropped);
    modport slave  (input in, output out, output busy, output dropped);
endinterface

// File: rtl/pulse_stretcher.sv
// Turns single-cycle internal events into clean output pulses with a guaranteed
// minimum high time and minimum low time; excess events are queued one deep or dropped.
module pulse_stretcher #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned RETRIGGER   = 0,
    parameter int unsigned CW          = 8
) (
    input  logic               clk,
    input  logic               reset,
    pulse_stretcher_if.slave   bus
);

    localparam int unsigned DW = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [DW-1:0] DROP_MAX  = '1;
    localparam logic [DW-1:0] DROP_ONE  = DW'(1);
    localparam bit            RETRIG    = (RETRIGGER != 0);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          in_d_q;
    logic          out_q, busy_q;
    logic [DW-1:0] dropped_q;
    logic          evt_c;
    logic          drop_c;

    assign evt_c = bus.in & ~in_d_q;

    // Next-state, counter and pending/drop decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        drop_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (evt_c) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (evt_c && RETRIG) begin
                    cnt_d = HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                if (evt_c && !RETRIG) begin
                    if (pend_q) drop_c = 1'b1;
                    else        pend_d = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    // A queued event wins; a fresh event here re-queues rather than drops
                    if (pend_q) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                        pend_d  = evt_c;
                    end else if (evt_c) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (evt_c) begin
                        if (pend_q) drop_c = 1'b1;
                        else        pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            in_d_q    <= 1'b0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            in_d_q  <= bus.in;
            out_q   <= (state_d == HOLD);
            busy_q  <= (state_d != IDLE);
            if (drop_c && (dropped_q != DROP_MAX)) begin
                dropped_q <= dropped_q + DROP_ONE;
            end
        end
    end

    assign bus.out     = out_q;
    assign bus.busy    = busy_q;
    assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: three configurations driven by one input, each checked
// every cycle against a timestamp-based model of the pulse/gap windows.
module tb_pulse_stretcher;

    localparam int NI = 3;
    localparam int H_A [NI] = '{4, 4, 1};
    localparam int G_A [NI] = '{2, 2, 1};
    localparam int R_A [NI] = '{0, 1, 0};

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic in_s  = 1'b0;

    always #5 clk = ~clk;

    pulse_stretcher_if ifc0 ();
    pulse_stretcher_if ifc1 ();
    pulse_stretcher_if ifc2 ();

    assign ifc0.in = in_s;
    assign ifc1.in = in_s;
    assign ifc2.in = in_s;

    pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(0), .CW(8))
        dut0 (.clk(clk), .reset(reset), .bus(ifc0));
    pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1), .CW(8))
        dut1 (.clk(clk), .reset(reset), .bus(ifc1));
    pulse_stretcher #(.HOLD_CYCLES(1), .GAP_CYCLES(1), .RETRIGGER(0), .CW(4))
        dut2 (.clk(clk), .reset(reset), .bus(ifc2));

    logic       d_out  [NI];
    logic       d_busy [NI];
    logic [7:0] d_drp  [NI];

    assign d_out[0] = ifc0.out;  assign d_busy[0] = ifc0.busy;  assign d_drp[0] = ifc0.dropped;
    assign d_out[1] = ifc1.out;  assign d_busy[1] = ifc1.busy;  assign d_drp[1] = ifc1.dropped;
    assign d_out[2] = ifc2.out;  assign d_busy[2] = ifc2.busy;  assign d_drp[2] = ifc2.dropped;

    int checks = 0;
    int errors = 0;

    // Model: each pulse is a window [hs, he) high followed by [he, ge) low, in edge numbers
    int hs [NI], he [NI], ge [NI], drp [NI], m_hi [NI];
    bit pend [NI], m_out [NI], m_busy [NI];
    bit ind;
    int cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            hs[i] = -1000; he[i] = -1000; ge[i] = -1000;
            pend[i] = 1'b0; drp[i] = 0;
            m_out[i] = 1'b0; m_busy[i] = 1'b0;
        end
        ind = 1'b0;
    endfunction

    function automatic void start_pulse(input int i, input int n);
        hs[i] = n;
        he[i] = n + H_A[i];
        ge[i] = he[i] + G_A[i];
    endfunction

    function automatic void queue_or_drop(input int i);
        if (pend[i]) begin
            if (drp[i] < 255) drp[i]++;
        end else begin
            pend[i] = 1'b1;
        end
    endfunction

    function automatic void model_step(input bit v);
        bit evt;
        bit was_hold, was_gap;
        int n;
        n   = cyc;
        evt = v && !ind;
        ind = v;
        for (int i = 0; i < NI; i++) begin
            was_hold = (hs[i] <= n - 1) && (n - 1 < he[i]);
            was_gap  = (he[i] <= n - 1) && (n - 1 < ge[i]);
            if (was_hold) begin
                if (evt && R_A[i] != 0) begin
                    he[i] = n + H_A[i];
                    ge[i] = he[i] + G_A[i];
                end else if (evt) begin
                    queue_or_drop(i);
                end
            end else if (was_gap) begin
                if (n == ge[i]) begin
                    if (pend[i]) begin
                        start_pulse(i, n);
                        pend[i] = evt;
                    end else if (evt) begin
                        start_pulse(i, n);
                    end
                end else if (evt) begin
                    queue_or_drop(i);
                end
            end else if (evt) begin
                start_pulse(i, n);
            end
            m_out[i]  = (hs[i] <= n) && (n < he[i]);
            m_busy[i] = (hs[i] <= n) && (n < ge[i]);
            if (m_out[i]) m_hi[i]++;
        end
        cyc++;
    endfunction

    // Per-cycle compare of every instance against the model
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_reset();
        end else begin
            model_step(in_s);
            #1;
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("out%0d", i),     int'(d_out[i]),  int'(m_out[i]));
                chk($sformatf("busy%0d", i),    int'(d_busy[i]), int'(m_busy[i]));
                chk($sformatf("dropped%0d", i), int'(d_drp[i]),  drp[i]);
            end
        end
    end

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            in_s = v;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_hi();
        for (int i = 0; i < NI; i++) m_hi[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) m_hi[i] = 0;
        #12;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_out%0d", i),  int'(d_out[i]),  0);
            chk($sformatf("rst_busy%0d", i), int'(d_busy[i]), 0);
            chk($sformatf("rst_drp%0d", i),  int'(d_drp[i]),  0);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(0, 5);

        // Single one-cycle event
        clear_hi();
        drive(1, 1);
        drive(0, 12);
        chk("single_hi0", m_hi[0], 4);
        chk("single_hi1", m_hi[1], 4);
        chk("single_hi2", m_hi[2], 1);

        // Level held high: one pulse only
        clear_hi();
        drive(1, 20);
        drive(0, 10);
        chk("level_hi0", m_hi[0], 4);
        chk("level_hi2", m_hi[2], 1);

        // Second event two cycles later: queued vs retriggered
        clear_hi();
        drive(1, 1); drive(0, 1); drive(1, 1);
        drive(0, 15);
        chk("queued_hi0", m_hi[0], 8);
        chk("retrig_hi1", m_hi[1], 6);
        chk("queued_hi2", m_hi[2], 2);
        chk("queued_drp0", drp[0], 0);

        // Third event lands on the hold->gap edge with a pending event
        drive(1, 1); drive(0, 1); drive(1, 1); drive(0, 1); drive(1, 1);
        drive(0, 15);
        chk("overflow_drp0", drp[0], 1);
        chk("overflow_drp1", drp[1], 0);

        // Flood of events: counter must saturate, not wrap
        repeat (600) begin
            drive(1, 1);
            drive(0, 1);
        end
        drive(0, 10);
        chk("sat_model0", drp[0], 255);
        chk("sat_dut0", int'(d_drp[0]), 255);

        // Randomized input with varying event density
        for (int blk = 0; blk < 6; blk++) begin
            int thr;
            thr = 10 + blk * 15;
            repeat (500) drive(($urandom_range(0, 99) < thr), 1);
        end
        drive(0, 10);

        // Asynchronous reset in the middle of a pulse, input already high on release
        drive(1, 1);
        drive(0, 2);
        #1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("arst_out%0d", i),  int'(d_out[i]),  0);
            chk($sformatf("arst_busy%0d", i), int'(d_busy[i]), 0);
            chk($sformatf("arst_drp%0d", i),  int'(d_drp[i]),  0);
        end
        in_s = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rel_out%0d", i), int'(d_out[i]), 1);
        end
        drive(1, 3);
        drive(0, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
